// File: rtl/johnson_seq_monitor.sv
// Johnson sequence monitor.
// Samples an 8-bit Johnson counter bus, decodes it to a 4-bit phase, checks that every
// qualified sample is the legal successor of the previous one and tracks lock. Errors
// seen while locked pulse seq_err, set a sticky flag and bump a saturating counter.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   johnson_in  Johnson counter bus under test
//   sample_en   qualifies johnson_in; when low all state holds
//   clr_err     synchronous clear of err_count and err_sticky (wins over a new error)
//   phase       decoded phase of the last legal sample
//   phase_valid last sample was a legal code
//   seq_err     one-cycle pulse per sequence / illegal-code error while locked
//   err_sticky  set by seq_err, cleared by clr_err or reset
//   locked      FSM is in LOCKED
//   err_count   saturating count of errors seen while locked
module johnson_seq_monitor #(
  parameter int unsigned LOCK_LEN    = 4,
  parameter bit          ALLOW_STALL = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       johnson_in,
  input  logic             sample_en,
  input  logic             clr_err,
  output logic [3:0]       phase,
  output logic             phase_valid,
  output logic             seq_err,
  output logic             err_sticky,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StSearch, StAcq, StLocked} state_e;

  state_e           state_q;
  logic [3:0]       prev_q;
  logic [3:0]       acq_cnt_q;
  logic [3:0]       phase_q;
  logic             phase_valid_q;
  logic             seq_err_q;
  logic             err_sticky_q;
  logic             locked_q;
  logic [CNT_W-1:0] err_count_q;

  logic       code_legal;
  logic [3:0] code_phase;
  logic       is_succ;
  logic       is_stall_ok;
  logic       err_event;
  logic       acq_done;

  // Phases 0..7 fill ones from the LSB, phases 8..15 drain them from the LSB.
  always_comb begin
    code_legal = 1'b0;
    code_phase = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (johnson_in == 8'((16'd1 << k) - 16'd1)) begin
        code_legal = 1'b1;
        code_phase = 4'(k);
      end
      if (johnson_in == 8'(16'h00ff << k)) begin
        code_legal = 1'b1;
        code_phase = 4'(k + 8);
      end
    end
  end

  always_comb begin
    // 4-bit add wraps phase 15 back to phase 0.
    is_succ     = code_legal && (code_phase == prev_q + 4'd1);
    is_stall_ok = ALLOW_STALL && code_legal && (code_phase == prev_q);
    err_event   = sample_en && (state_q == StLocked) && !is_succ && !is_stall_ok;
    acq_done    = ({1'b0, acq_cnt_q} + 5'd1) == 5'(LOCK_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StSearch;
      prev_q        <= 4'd0;
      acq_cnt_q     <= 4'd0;
      phase_q       <= 4'd0;
      phase_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      seq_err_q <= err_event;

      if (sample_en) begin
        phase_valid_q <= code_legal;
        if (code_legal) begin
          phase_q <= code_phase;
        end

        unique case (state_q)
          StSearch: begin
            if (code_legal) begin
              state_q   <= StAcq;
              prev_q    <= code_phase;
              acq_cnt_q <= 4'd0;
            end
          end
          StAcq: begin
            if (!code_legal) begin
              state_q   <= StSearch;
              acq_cnt_q <= 4'd0;
            end else if (is_succ) begin
              prev_q <= code_phase;
              if (acq_done) begin
                state_q   <= StLocked;
                locked_q  <= 1'b1;
                acq_cnt_q <= 4'd0;
              end else begin
                acq_cnt_q <= acq_cnt_q + 4'd1;
              end
            end else if (!is_stall_ok) begin
              // Wrong legal code restarts acquisition from the new phase.
              acq_cnt_q <= 4'd0;
              prev_q    <= code_phase;
            end
          end
          StLocked: begin
            if (!code_legal) begin
              state_q  <= StSearch;
              locked_q <= 1'b0;
            end else if (is_succ) begin
              prev_q <= code_phase;
            end else if (!is_stall_ok) begin
              state_q   <= StAcq;
              locked_q  <= 1'b0;
              acq_cnt_q <= 4'd0;
              prev_q    <= code_phase;
            end
          end
          default: begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end
        endcase
      end

      // Clear has priority over a coincident error; seq_err still pulses.
      if (clr_err) begin
        err_count_q  <= '0;
        err_sticky_q <= 1'b0;
      end else if (err_event) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != {CNT_W{1'b1}}) begin
          err_count_q <= err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign seq_err     = seq_err_q;
  assign err_sticky  = err_sticky_q;
  assign locked      = locked_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Scoreboard bench for johnson_seq_monitor: two instances (stall allowed / not allowed)
// driven by the same stimulus; a reference model pushes expected outputs per sample.
module tb_johnson_seq_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] johnson_in = 8'h00;
  logic       sample_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [3:0] phase_a, phase_b;
  logic       phase_valid_a, phase_valid_b;
  logic       seq_err_a, seq_err_b;
  logic       err_sticky_a, err_sticky_b;
  logic       locked_a, locked_b;
  logic [7:0] err_count_a, err_count_b;

  johnson_seq_monitor #(.LOCK_LEN(4), .ALLOW_STALL(1'b1), .CNT_W(8)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .johnson_in  (johnson_in),
    .sample_en   (sample_en),
    .clr_err     (clr_err),
    .phase       (phase_a),
    .phase_valid (phase_valid_a),
    .seq_err     (seq_err_a),
    .err_sticky  (err_sticky_a),
    .locked      (locked_a),
    .err_count   (err_count_a)
  );

  johnson_seq_monitor #(.LOCK_LEN(4), .ALLOW_STALL(1'b0), .CNT_W(8)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .johnson_in  (johnson_in),
    .sample_en   (sample_en),
    .clr_err     (clr_err),
    .phase       (phase_b),
    .phase_valid (phase_valid_b),
    .seq_err     (seq_err_b),
    .err_sticky  (err_sticky_b),
    .locked      (locked_b),
    .err_count   (err_count_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cur = 0;

  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  logic [7:0]  code_tab[16];

  // Model state, index 0 = stall allowed, 1 = stall not allowed. st: 0 search, 1 acq, 2 locked.
  int m_st[2], m_prev[2], m_acq[2], m_phase[2], m_pv[2], m_se[2], m_sticky[2], m_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs_a();
    return {phase_a, phase_valid_a, seq_err_a, err_sticky_a, locked_a, err_count_a};
  endfunction

  function automatic logic [15:0] obs_b();
    return {phase_b, phase_valid_b, seq_err_b, err_sticky_b, locked_b, err_count_b};
  endfunction

  function automatic logic [15:0] model_pack(input int d);
    logic lk;
    lk = (m_st[d] == 2);
    return {4'(m_phase[d]), 1'(m_pv[d]), 1'(m_se[d]), 1'(m_sticky[d]), lk, 8'(m_cnt[d])};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_prev[d] = 0; m_acq[d] = 0; m_phase[d] = 0;
      m_pv[d] = 0; m_se[d] = 0; m_sticky[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit allow, input logic [7:0] code,
                            input logic en, input logic clr);
    bit legal, succ, stall, err;
    int ph;
    legal = 0; ph = 0; err = 0;
    for (int k = 0; k < 16; k++) begin
      if (code_tab[k] == code) begin
        legal = 1;
        ph = k;
      end
    end
    if (en) begin
      if (legal) m_phase[d] = ph;
      m_pv[d] = legal;
      succ  = legal && (ph == (m_prev[d] + 1) % 16);
      stall = legal && allow && (ph == m_prev[d]);
      case (m_st[d])
        0: if (legal) begin m_st[d] = 1; m_prev[d] = ph; m_acq[d] = 0; end
        1: begin
          if (!legal) m_st[d] = 0;
          else if (succ) begin
            m_acq[d]++;
            m_prev[d] = ph;
            if (m_acq[d] == 4) begin m_st[d] = 2; m_acq[d] = 0; end
          end else if (!stall) begin
            m_acq[d] = 0;
            m_prev[d] = ph;
          end
        end
        default: begin
          if (!legal) begin err = 1; m_st[d] = 0; end
          else if (succ) m_prev[d] = ph;
          else if (!stall) begin err = 1; m_st[d] = 1; m_acq[d] = 0; m_prev[d] = ph; end
        end
      endcase
    end
    m_se[d] = err;
    if (clr) begin
      m_cnt[d] = 0;
      m_sticky[d] = 0;
    end else if (err) begin
      m_sticky[d] = 1;
      if (m_cnt[d] < 255) m_cnt[d]++;
    end
  endtask

  // Drive one sample, push expectations, then compare after the edge.
  task automatic step(input logic [7:0] code, input logic en = 1'b1, input logic clr = 1'b0);
    johnson_in = code;
    sample_en  = en;
    clr_err    = clr;
    model_step(0, 1'b1, code, en, clr);
    model_step(1, 1'b0, code, en, clr);
    sb_a.push_back(model_pack(0));
    sb_b.push_back(model_pack(1));
    @(posedge clk);
    #1;
    check("sb_a", obs_a(), sb_a.pop_front());
    check("sb_b", obs_b(), sb_b.pop_front());
    clr_err = 1'b0;
  endtask

  task automatic run_legal(input int n);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % 16;
      step(code_tab[cur]);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      code_tab[k] = (k < 8) ? 8'((1 << k) - 1) : 8'(256 - (1 << (k - 8)));
    end
    model_reset();

    #12;
    check("reset_a", obs_a(), 16'h0);
    check("reset_b", obs_b(), 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Acquire and lock on the first legal run.
    cur = 0;
    step(code_tab[0]);
    run_legal(4);
    check("lock_after_0f", locked_a, 1'b1);
    run_legal(1);

    // Long legal stream across the 0x80 -> 0x00 wrap.
    run_legal(40);
    check("wrap_cnt", err_count_a, 8'd0);
    check("wrap_lock", locked_a, 1'b1);

    // Wrong legal code while locked at phase 3.
    while (cur != 3) run_legal(1);
    step(8'h3f);
    cur = 6;
    check("wrong_seq_err", seq_err_a, 1'b1);
    check("wrong_cnt", err_count_a, 8'd1);
    check("wrong_sticky", err_sticky_a, 1'b1);
    check("wrong_unlock", locked_a, 1'b0);
    run_legal(4);
    check("relock_wrong", locked_a, 1'b1);

    // Illegal code while locked.
    step(8'h5a);
    check("illegal_pv", phase_valid_a, 1'b0);
    check("illegal_phase_held", phase_a, 4'd10);
    check("illegal_seq_err", seq_err_a, 1'b1);
    cur = 0;
    run_legal(5);
    check("relock_illegal", locked_a, 1'b1);

    // Stall at 0x0F while locked.
    while (cur != 4) run_legal(1);
    for (int i = 0; i < 9; i++) step(code_tab[4]);
    check("stall_a_cnt", err_count_a, 8'd2);
    check("stall_a_lock", locked_a, 1'b1);
    check("stall_b_cnt", err_count_b, 8'd3);
    check("stall_b_lock", locked_b, 1'b0);
    run_legal(5);
    check("stall_b_relock", locked_b, 1'b1);

    // sample_en low with garbage: nothing moves.
    for (int i = 0; i < 8; i++) step(8'($urandom), 1'b0);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      step(8'h5a);
      run_legal(5);
    end
    check("sat_a", err_count_a, 8'hff);
    check("sat_b", err_count_b, 8'hff);

    // Clear coincident with an error: clear wins, pulse still seen.
    step(8'h5a, 1'b1, 1'b1);
    check("clr_cnt", err_count_a, 8'd0);
    check("clr_sticky", err_sticky_a, 1'b0);
    check("clr_seq_err", seq_err_a, 1'b1);
    run_legal(5);
    cur = (cur + 1) % 16;
    step(code_tab[cur], 1'b1, 1'b1);
    check("clr_keeps_lock", locked_a, 1'b1);

    // Asynchronous reset mid-stream.
    run_legal(3);
    #2;
    sample_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_a", obs_a(), 16'h0);
    check("rst_mid_b", obs_b(), 16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh acquisition, then an upstream counter parked at 0x00.
    cur = 0;
    step(code_tab[0]);
    run_legal(16);
    for (int i = 0; i < 5; i++) step(code_tab[0]);
    check("park_a_cnt", err_count_a, 8'd0);
    check("park_a_lock", locked_a, 1'b1);
    check("park_b_cnt", err_count_b, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
